// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache with combinational hit path and a byte-serial
// line fill from memory; saturating hit/miss statistics.
module icache_dm_param #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [31:0]       data_o,
    output logic              valid_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    input  logic              mem_done_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int LINES  = 1 << INDEX_W;
    localparam int BYTES  = 1 << OFFSET_W;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W = 8 * BYTES;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINE_W-1:0]   data_q [LINES];
    logic [LINE_W-1:0]   fbuf;
    logic [ADDR_W-1:0]   base_q;
    logic [OFFSET_W-1:0] cnt_q;

    logic [INDEX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]    req_tag, fill_tag;
    logic [OFFSET_W-1:0] word_off;
    logic [LINE_W-1:0]   line_rd, line_wr;
    logic                hit, fill_done;

    assign req_idx  = addr_i[OFFSET_W +: INDEX_W];
    assign req_tag  = addr_i[ADDR_W-1 -: TAG_W];
    assign fill_idx = base_q[OFFSET_W +: INDEX_W];
    assign fill_tag = base_q[ADDR_W-1 -: TAG_W];
    // Masking instead of slicing [OFFSET_W-1:2] keeps OFFSET_W=2 legal.
    assign word_off = addr_i[OFFSET_W-1:0] & ~OFFSET_W'(3);

    assign hit = (state == IDLE) && req_i && !flush_i && valid_q[req_idx]
                 && (tag_q[req_idx] == req_tag);
    assign line_rd = data_q[req_idx];
    assign valid_o = hit;
    assign data_o  = hit ? line_rd[{word_off, 3'b000} +: 32] : '0;

    assign fill_done  = (state == FILL) && mem_done_i && !flush_i && (cnt_q == '1);
    assign mem_req_o  = (state == FILL);
    assign mem_addr_o = (state == FILL) ? (base_q | ADDR_W'(cnt_q)) : '0;

    always_comb begin
        line_wr = fbuf;
        line_wr[LINE_W-1 -: 8] = mem_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (valid_o && (hit_cnt_o != '1))
                hit_cnt_o <= hit_cnt_o + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        valid_q <= '0;
                    end else if (req_i && !hit) begin
                        base_q <= {addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        cnt_q  <= '0;
                        state  <= FILL;
                        if (miss_cnt_o != '1)
                            miss_cnt_o <= miss_cnt_o + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        valid_q <= '0;
                        state   <= IDLE;
                    end else if (mem_done_i) begin
                        cnt_q <= cnt_q + OFFSET_W'(1);
                        if (cnt_q == '1) begin
                            valid_q[fill_idx] <= 1'b1;
                            state             <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_done_i)
            fbuf[{cnt_q, 3'b000} +: 8] <= mem_data_i;
        if (fill_done) begin
            data_q[fill_idx] <= line_wr;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm_param.sv
// Bench for icache_dm_param: directed scenarios then random traffic, checked
// against an abstract cache model; a second instance checks counter saturation.
module tb_icache_dm_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush_i, req_i, done_en;
    logic [31:0] addr_i;
    logic [31:0] data_o, data_s, mem_addr_o, mem_addr_s, hit_cnt, miss_cnt;
    logic        valid_o, valid_s, mem_req_o, mem_req_s;
    logic [7:0]  mem_data;
    logic [3:0]  hit_s, miss_s;

    // Memory returns the low byte of the requested address.
    assign mem_data = mem_addr_o[7:0];

    icache_dm_param #(.ADDR_W(32), .INDEX_W(6), .OFFSET_W(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .req_i(req_i), .addr_i(addr_i),
        .data_o(data_o), .valid_o(valid_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_data_i(mem_data), .mem_done_i(done_en),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    icache_dm_param #(.ADDR_W(32), .INDEX_W(6), .OFFSET_W(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush_i(flush_i), .req_i(req_i), .addr_i(addr_i),
        .data_o(data_s), .valid_o(valid_s), .mem_req_o(mem_req_s),
        .mem_addr_o(mem_addr_s), .mem_data_i(mem_data), .mem_done_i(done_en),
        .hit_cnt_o(hit_s), .miss_cnt_o(miss_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Abstract model: which lines hold which tag; contents follow from memory.
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    bit          m_fill;
    logic [31:0] m_base;
    int          m_cnt;
    longint      m_hits, m_miss;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0] & 8'hFC;
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [63:0] sat15(input longint v);
        return (v > 15) ? 64'd15 : 64'(v);
    endfunction

    function automatic bit m_hit();
        int idx;
        idx = int'(addr_i[9:4]);
        return !m_fill && req_i && !flush_i && m_valid[idx] && (m_tag[idx] == addr_i[31:10]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic apply(input bit r, input bit f, input bit q, input logic [31:0] a, input bit d);
        rst = r; flush_i = f; req_i = q; addr_i = a; done_en = d;
        #2;
    endtask

    task automatic compare_model();
        bit h;
        h = m_hit();
        check("valid_o",    valid_o,    h);
        check("data_o",     data_o,     h ? mem_word(addr_i) : 32'h0);
        check("mem_req_o",  mem_req_o,  m_fill);
        check("mem_addr_o", mem_addr_o, m_fill ? m_base + 32'(m_cnt) : 32'h0);
        check("hit_cnt",    hit_cnt,    64'(m_hits));
        check("miss_cnt",   miss_cnt,   64'(m_miss));
        check("sat_valid",  valid_s,    h);
        check("sat_addr",   mem_addr_s, m_fill ? m_base + 32'(m_cnt) : 32'h0);
        check("sat_hit",    hit_s,      sat15(m_hits));
        check("sat_miss",   miss_s,     sat15(m_miss));
    endtask

    // Advance the model by the effect of the coming edge, then take the edge.
    task automatic tick();
        bit h;
        h = m_hit();
        if (!rst) begin
            m_fill = 1'b0; m_cnt = 0; m_hits = 0; m_miss = 0;
            clear_model();
        end else if (m_fill) begin
            if (flush_i) begin
                m_fill = 1'b0;
                clear_model();
            end else if (done_en) begin
                m_cnt++;
                if (m_cnt == 16) begin
                    m_valid[int'(m_base[9:4])] = 1'b1;
                    m_tag[int'(m_base[9:4])]   = m_base[31:10];
                    m_fill = 1'b0;
                end
            end
        end else begin
            if (h) m_hits++;
            if (flush_i) clear_model();
            else if (req_i && !h) begin
                m_fill = 1'b1;
                m_base = addr_i & ~32'hF;
                m_cnt  = 0;
                m_miss++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit r, input bit f, input bit q, input logic [31:0] a, input bit d);
        apply(r, f, q, a, d);
        compare_model();
        tick();
    endtask

    task automatic run_fill(input logic [31:0] a);
        step(1, 0, 1, a, 1);
        for (int i = 0; i < 40 && m_fill; i++) step(1, 0, 1, a, 1);
    endtask

    initial begin
        m_fill = 1'b0; m_cnt = 0; m_hits = 0; m_miss = 0; m_base = '0;
        clear_model();
        @(posedge clk); #1;

        // Reset held two cycles; first cycle outputs are not yet defined.
        apply(0, 0, 0, 32'h0, 0);
        tick();
        step(0, 0, 0, 32'h0, 0);
        apply(1, 0, 0, 32'h0, 0);
        compare_model();
        check("rst_miss", miss_cnt, 0);
        tick();

        // Cold miss then hit
        run_fill(32'h104);
        apply(1, 0, 1, 32'h104, 0);
        compare_model();
        check("cold_valid", valid_o, 1);
        check("cold_data",  data_o, 32'h07060504);
        check("cold_miss",  miss_cnt, 1);
        tick();

        apply(1, 0, 1, 32'h10C, 0);
        compare_model();
        check("hit_data",   data_o, 32'h0F0E0D0C);
        check("hit_memreq", mem_req_o, 0);
        tick();
        check("hit_cnt2", hit_cnt, 2);

        // Conflict on index 0x10
        run_fill(32'h504);
        apply(1, 0, 1, 32'h504, 0);
        compare_model();
        check("conf_data", data_o, 32'h07060504);
        tick();
        run_fill(32'h104);
        check("conf_miss", miss_cnt, 3);

        // Flush after 5 bytes, then refetch from byte 0
        step(1, 0, 1, 32'h208, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 32'h208, 1);
        step(1, 1, 1, 32'h208, 0);
        apply(1, 0, 0, 32'h208, 0);
        compare_model();
        check("flush_memreq", mem_req_o, 0);
        tick();
        step(1, 0, 1, 32'h208, 0);
        apply(1, 0, 1, 32'h208, 1);
        compare_model();
        check("refetch_addr", mem_addr_o, 32'h200);
        tick();
        for (int i = 0; i < 40 && m_fill; i++) step(1, 0, 1, 32'h208, 1);

        // Flush coinciding with the final byte must not install
        step(1, 0, 1, 32'h3A0, 1);
        for (int i = 0; i < 15; i++) step(1, 0, 1, 32'h3A0, 1);
        step(1, 1, 1, 32'h3A0, 1);
        apply(1, 0, 1, 32'h3A0, 0);
        compare_model();
        check("abort_noinstall", valid_o, 0);
        tick();
        for (int i = 0; i < 40 && m_fill; i++) step(1, 0, 1, 32'h3A0, 1);

        // Repeated conflicting misses saturate the 4-bit counter
        for (int i = 0; i < 16; i++) run_fill((i % 2 == 0) ? 32'h2300 : 32'h6300);
        check("sat_miss_F", miss_s, 4'hF);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                | 32'($urandom_range(0, 15));
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), a, ($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_dm_param.md
ICACHE_DM_PARAM -- requirements
Module: icache_dm_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter INDEX_W, default 6, index bits; 2^INDEX_W lines.
REQ-003 SHALL have parameter OFFSET_W, default 4, line offset bits; 2^OFFSET_W bytes/line, legal range 2..6.
REQ-004 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 flush_i  input  1  invalidate all lines.
REQ-008 req_i  input  1  fetch request.
REQ-009 addr_i  input  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-010 data_o  output  32  fetched word, little-endian.
REQ-011 valid_o  output  1  data_o valid this cycle.
REQ-012 mem_req_o  output  1  memory byte read request.
REQ-013 mem_addr_o  output  ADDR_W  memory byte address.
REQ-014 mem_data_i  input  8  memory read byte.
REQ-015 mem_done_i  input  1  mem_data_i valid; completes current byte.
REQ-016 hit_cnt_o  output  CNT_W  hit count.
REQ-017 miss_cnt_o  output  CNT_W  miss count.

Function
REQ-018 SHALL be direct-mapped: offset = addr_i[OFFSET_W-1:0], index = addr_i[OFFSET_W+INDEX_W-1:OFFSET_W], tag = remaining upper bits.
REQ-019 SHALL store per line: valid bit, tag, 2^OFFSET_W data bytes.
REQ-020 SHALL implement FSM IDLE, FILL; reset state IDLE.
REQ-021 Hit (IDLE, req_i=1, line valid, tag equal) SHALL drive valid_o=1 and data_o = word at addr_i[OFFSET_W-1:2] combinationally, same cycle, zero latency.
REQ-022 valid_o SHALL be 0 and data_o SHALL be 0 whenever no hit is signalled, including all FILL cycles.
REQ-023 Miss in IDLE (req_i=1, no hit, flush_i=0) SHALL latch line base address (addr_i with offset zeroed), clear byte counter, enter FILL next edge.
REQ-024 In FILL, mem_req_o SHALL be 1 and mem_addr_o = base + byte counter, held stable until mem_done_i sampled 1.
REQ-025 On mem_done_i=1 in FILL, mem_data_i SHALL be written to fill buffer at byte counter, counter SHALL increment; mem_req_o stays 1 for next byte without gap.
REQ-026 On mem_done_i for byte 2^OFFSET_W-1, SHALL install buffer, latched tag and valid=1 into line, return to IDLE; request hits the cycle after.
REQ-027 Miss latency SHALL be 2^OFFSET_W memory completions plus 1 cycle.
REQ-028 Fill SHALL complete for latched address even if req_i drops or addr_i changes; no abort except flush/reset.
REQ-029 mem_done_i while mem_req_o=0 SHALL be ignored; mem_req_o=0 and mem_addr_o=0 in IDLE.
REQ-030 flush_i=1 in IDLE SHALL clear all valid bits at edge; no hit signalled that cycle.
REQ-031 flush_i=1 in FILL SHALL abort: no install (even if final mem_done_i same cycle), clear all valid bits, IDLE next edge, mem_req_o=0 next cycle.
REQ-032 hit_cnt_o SHALL increment once per cycle with valid_o=1; miss_cnt_o SHALL increment once per IDLE->FILL transition; both saturate at 2^CNT_W-1; flush_i SHALL NOT clear them.

Reset
REQ-033 rst=0 at edge SHALL: FSM IDLE, all valid bits 0, byte counter 0, counters 0; mem_req_o, valid_o, data_o, mem_addr_o 0 next cycle.
REQ-034 Reset during FILL SHALL abort fill with no install; tag/data arrays need no reset.

Verification (INDEX_W=6, OFFSET_W=4; memory returns byte = addr[7:0], 1-cycle done)
REQ-035 Hold rst=0 2 cycles, release, req_i=0 -> all outputs 0, hit_cnt_o=miss_cnt_o=0.
REQ-036 Cold req 0x104 -> FILL, mem_addr_o 0x100..0x10F, 16 dones; then valid_o=1, data_o=0x07060504, miss_cnt_o=1.
REQ-037 Then req 0x10C -> same-cycle valid_o=1, data_o=0x0F0E0D0C, mem_req_o=0, hit_cnt_o +1.
REQ-038 Req 0x504 (index 0x10, new tag) -> miss, refill 0x500..0x50F, data_o=0x07060504; then req 0x104 misses again, miss_cnt_o=3.
REQ-039 flush_i=1 after 5 bytes of fill -> mem_req_o=0 next cycle; same req misses again, refetch starts at base byte 0.
REQ-040 Preload miss_cnt_o near saturation with CNT_W=4: 16 misses -> miss_cnt_o stays 0xF.
